// File: rtl/bus_master_pkg.sv
// Shared types for the on-chip AXI4-Lite initiator: response codes and the
// local command/response records exchanged with the sequencer.
package bus_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    axi_resp_t         resp;
    logic              timeout;
  } bus_rsp_t;

endpackage

// File: rtl/bus_master.sv
// Single-outstanding AXI4-Lite initiator: one local command -> one AXI
// transaction -> one response. Optional watchdog: define BUS_MASTER_TIMEOUT_EN.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [STRB_W-1:0] M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t   state, state_nxt;
  bus_cmd_t cmd_q;
  bus_rsp_t rsp_q;
  logic     aw_done, w_done;
  logic     cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic     busy, expire;

  // Channel controls decode straight from registered state so reset drops them at once.
  assign cmd_ready     = (state == IDLE);
  assign M_AXI_AWVALID = (state == WADDR) && !aw_done;
  assign M_AXI_WVALID  = (state == WADDR) && !w_done;
  assign M_AXI_BREADY  = (state == WRESP);
  assign M_AXI_ARVALID = (state == RADDR);
  assign M_AXI_RREADY  = (state == RDATA);
  assign rsp_valid     = (state == RSP);

  assign M_AXI_AWADDR = cmd_q.addr;
  assign M_AXI_ARADDR = cmd_q.addr;
  assign M_AXI_WDATA  = cmd_q.wdata;
  assign M_AXI_WSTRB  = cmd_q.wstrb;

  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_resp    = rsp_q.resp;
  assign rsp_timeout = rsp_q.timeout;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
  assign busy   = (state == WADDR) || (state == WRESP) ||
                  (state == RADDR) || (state == RDATA);

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;

  // Saturates so a late expiry keeps firing in later busy states.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)                 wd_cnt <= '0;
    else if (cmd_hs)                    wd_cnt <= '0;
    else if (busy && wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign expire = busy && (wd_cnt == CNT_MAX);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  // Handshakes are tested before expiry so a same-cycle handshake wins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
               else if (expire)                            state_nxt = RSP;
      WRESP:   if (b_hs || expire)  state_nxt = RSP;
      RADDR:   if (ar_hs)           state_nxt = RDATA;
               else if (expire)     state_nxt = RSP;
      RDATA:   if (r_hs || expire)  state_nxt = RSP;
      RSP:     if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      cmd_q   <= '0;
      rsp_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        cmd_q   <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == WADDR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs || r_hs) begin
        rsp_q <= '{rdata:   cmd_q.write ? '0 : M_AXI_RDATA,
                   resp:    axi_resp_t'(cmd_q.write ? M_AXI_BRESP : M_AXI_RRESP),
                   timeout: 1'b0};
      end else if (expire && state_nxt == RSP) begin
        rsp_q <= '{rdata: '0, resp: AXI_SLVERR, timeout: 1'b1};
      end
    end
  end

endmodule

// File: doc/bus_master.md
# bus_master

Single-outstanding AXI4-Lite style initiator (32-bit address, 64-bit data) that drives the accelerator's slave register port from an on-chip command stream. It converts one local command (write or read) into one AXI transaction and returns one response. It sits in front of the accelerator top's `S_AXI_*` port for on-chip sequencing and standalone bring-up without a processing system.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles (used only with `BUS_MASTER_TIMEOUT_EN`).

Ports:
- `M_AXI_ACLK` in 1: the single clock.
- `M_AXI_ARESETN` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accept.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 64: write data.
- `cmd_wstrb` in 8: write strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 64: read data (0 for writes).
- `rsp_resp` out 2: AXI BRESP/RRESP.
- `rsp_timeout` out 1: transaction aborted by the watchdog.
- AXI master channels, all standard widths:
  - AW: `M_AXI_AWADDR`/`AWVALID`/`AWREADY`.
  - W: `M_AXI_WDATA`/`WSTRB`/`WVALID`/`WREADY`.
  - B: `M_AXI_BRESP`/`BVALID`/`BREADY`.
  - AR: `M_AXI_ARADDR`/`ARVALID`/`ARREADY`.
  - R: `M_AXI_RDATA`/`RRESP`/`RVALID`/`RREADY`.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr/wdata/wstrb/write.
  - Go to WADDR if write, else RADDR.
- WADDR:
  - AWVALID and WVALID assert together.
  - Each drops independently on its own handshake; AW and W may complete in either order or the same cycle.
  - Go to WRESP once both have completed.
- WRESP: BREADY=1. On BVALID, capture BRESP, set `rsp_rdata`=0, go to RSP.
- RADDR: ARVALID=1. On ARREADY, go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP: `rsp_valid`=1, held with stable data until `rsp_ready`, then go to IDLE.
- AXI VALID signals never drop before their handshake. Address and data outputs are stable while VALID is asserted.
- At most one transaction is outstanding; `cmd_ready`=0 in every state except IDLE.
- Response slave errors (SLVERR/DECERR) are passed through unmodified; they are not an abort condition.

## Timing
- Reset (async assert, sync deassert assumed by system): state=IDLE. All outputs 0 (valids, readies, addr, data, `rsp_*`) except `cmd_ready`=1.
- Reset mid-transaction: all VALID/READY signals drop immediately, FSM returns to IDLE, any pending response is lost.
- Write, zero-wait slave:
  - cmd handshake at cycle 0.
  - AW/W valid at cycle 1, accepted at 1.
  - BREADY at 2, BVALID at 2.
  - `rsp_valid` at 3.
- Read, zero-wait slave:
  - cmd handshake at cycle 0.
  - ARVALID at 1.
  - RREADY at 2.
  - `rsp_valid` at 3.
- Back-to-back: the next command is accepted the cycle after the `rsp_ready` handshake. Minimum cycle time is 4 cycles per transaction with a zero-wait slave.
- AWREADY and WREADY in different cycles: WRESP is entered the cycle after the later of the two.

## Configuration
- `BUS_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to WADDR/RADDR and increments each cycle in WADDR/WRESP/RADDR/RDATA.
  - When it reaches `TIMEOUT_CYCLES`, all AXI VALID/READY drop, the FSM enters RSP, and the response is `rsp_timeout`=1, `rsp_resp`=2'b10, `rsp_rdata`=0.
  - A handshake that lands in the same cycle as expiry wins; the normal response is returned.
- Not defined: no counter logic is present, `rsp_timeout` is tied to 0, and the FSM waits indefinitely.

## Structure
- Shared package (alongside the existing replica package) gets:
  - `axi_resp_t` (2-bit) with OKAY/EXOKAY/SLVERR/DECERR constants.
  - `bus_cmd_t` struct: write, addr, wdata, wstrb.
  - `bus_rsp_t` struct: rdata, resp, timeout.
- FSM state enum stays local to the module.
- No sub-module; the watchdog is an inline `ifdef` block.

## Test plan
- Write 0x0000_0010, data 0x0123_4567_89AB_CDEF, strb 0xFF, zero-wait slave -> AW/W at cycle 1, `rsp_valid` at cycle 3, resp 0, rdata 0.
- Read 0x0000_0020 with slave RDATA 0xDEAD_BEEF_0000_0001, ARREADY delayed 3 cycles -> ARVALID held 4 cycles, `rsp_rdata` equals the slave data, resp 0.
- Write with WREADY 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held; exactly one B handshake.
- `rsp_ready` held low 5 cycles, `cmd_valid` high -> `cmd_ready` stays 0 and the response is stable; the next command is accepted the cycle after `rsp_ready`.
- `BUS_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, slave never asserts BVALID -> `rsp_timeout`=1, resp 2'b10, BREADY low after abort.
- `M_AXI_ARESETN` asserted while in RDATA -> RREADY is 0 immediately, `cmd_ready`=1 after release, no `rsp_valid`.
